// File: rtl/mask_arb_pkg.sv
// Shared definitions for the mask RAM arbiter: default address width,
// grant encoding and bulk-clear state encoding.
package mask_arb_pkg;

    localparam int ADDR_W_DEFAULT = 14;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2,
        GNT_CLR  = 2'd3
    } gnt_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/mask_clear_seq.sv
// Bulk-clear sequencer: walks every RAM address once, writing a latched fill value.
// Only instantiated when MASK_ARB_CLEAR_EN is defined.
module mask_clear_seq
    import mask_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              start_i,
    input  logic              val_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              val_o
);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              val_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        val_q   <= val_i;
                    end
                end
                ST_CLEAR: begin
                    // Termination is by compare to all-ones; start requests are ignored here.
                    if (&cnt_q) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy_o = (state_q == ST_CLEAR);
    assign addr_o = cnt_q;
    assign val_o  = val_q;

endmodule

// File: rtl/mask_ram_arbiter.sv
// Mask RAM arbiter: round-robin RD/WR sharing of the 1-bit single-port mask RAM,
// with an optional bulk clear that takes priority (built when MASK_ARB_CLEAR_EN is defined).
module mask_ram_arbiter
    import mask_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_clearReq,
    input  logic              i_clearVal,
    output logic              o_clearBusy,
    input  logic              i_wrValid,
    output logic              o_wrReady,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic              i_wrData,
    input  logic              i_rdValid,
    output logic              o_rdReady,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic              o_rdDataValid,
    output logic              o_rdData,
    output logic [ADDR_W-1:0] o_ramAddrIn,
    output logic [ADDR_W-1:0] o_ramAddrOut,
    output logic              o_ramDataIn,
    output logic              o_ramCs,
    output logic              o_ramWe,
    input  logic              i_ramDataOut
);

    logic              clr_busy;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_val;

`ifdef MASK_ARB_CLEAR_EN
    mask_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .nRst    (nRst),
        .start_i (i_clearReq),
        .val_i   (i_clearVal),
        .busy_o  (clr_busy),
        .addr_o  (clr_addr),
        .val_o   (clr_val)
    );
`else
    logic unused_clear;
    assign unused_clear = i_clearReq ^ i_clearVal;
    assign clr_busy     = 1'b0;
    assign clr_addr     = '0;
    assign clr_val      = 1'b0;
`endif

    gnt_e gnt;
    gnt_e last_gnt_q, last_gnt_d;
    logic rd_valid_q;

    // Clear wins outright; on a RD/WR conflict the side not served last goes first.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        gnt = GNT_NONE;
        if (clr_busy) begin
            gnt = GNT_CLR;
        end else if (i_rdValid && i_wrValid) begin
            gnt = (last_gnt_q == GNT_RD) ? GNT_WR : GNT_RD;
        end else if (i_rdValid) begin
            gnt = GNT_RD;
        end else if (i_wrValid) begin
            gnt = GNT_WR;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt == GNT_RD || gnt == GNT_WR) begin
            last_gnt_d = gnt;
        end
    end

    always_comb begin
        o_ramCs      = 1'b0;
        o_ramWe      = 1'b0;
        o_ramAddrIn  = i_wrAddr;
        o_ramAddrOut = i_rdAddr;
        o_ramDataIn  = i_wrData;
        case (gnt)
            GNT_RD: begin
                o_ramCs = 1'b1;
            end
            GNT_WR: begin
                o_ramCs = 1'b1;
                o_ramWe = 1'b1;
            end
            GNT_CLR: begin
                o_ramCs     = 1'b1;
                o_ramWe     = 1'b1;
                o_ramAddrIn = clr_addr;
                o_ramDataIn = clr_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            last_gnt_q <= GNT_RD;
            rd_valid_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rd_valid_q <= (gnt == GNT_RD);
        end
    end

    assign o_rdReady     = (gnt == GNT_RD);
    assign o_wrReady     = (gnt == GNT_WR);
    assign o_clearBusy   = clr_busy;
    assign o_rdDataValid = rd_valid_q;
    // RAM read data is already registered; gating keeps o_rdData at 0 outside a return.
    assign o_rdData      = rd_valid_q & i_ramDataOut;

endmodule

// File: tb/tb_mask_ram_arbiter.sv
// Self-checking bench for mask_ram_arbiter: behavioural RAM, scoreboard memory and
// arbitration model; clear scenarios run when MASK_ARB_CLEAR_EN is defined.
module tb_mask_ram_arbiter;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;
    localparam int BOUND = 20000;
`ifdef MASK_ARB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          clear_req = 1'b0, clear_val = 1'b0;
    logic          rd_valid = 1'b0, wr_valid = 1'b0, wr_data = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic          clear_busy, wr_ready, rd_ready, rd_data_valid, rd_data;
    logic [AW-1:0] ram_addr_in, ram_addr_out;
    logic          ram_data_in, ram_cs, ram_we;
    logic          ram_dout = 1'b0;

    // Stand-in for the physical RAM, and the scoreboard's idea of its contents.
    bit ram     [DEPTH];
    bit ref_mem [DEPTH];

    int clr_left;
    bit clr_fill;
    bit last_was_rd = 1'b1;
    bit rd_pend, rd_pend_data;
    bit acc_rd, acc_wr;
    logic obs_wr_ready, obs_rd_ready, obs_busy, obs_cs;
    int vectors = 0;
    int miscompares = 0;

    mask_ram_arbiter #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .nRst          (nRst),
        .i_clearReq    (clear_req),
        .i_clearVal    (clear_val),
        .o_clearBusy   (clear_busy),
        .i_wrValid     (wr_valid),
        .o_wrReady     (wr_ready),
        .i_wrAddr      (wr_addr),
        .i_wrData      (wr_data),
        .i_rdValid     (rd_valid),
        .o_rdReady     (rd_ready),
        .i_rdAddr      (rd_addr),
        .o_rdDataValid (rd_data_valid),
        .o_rdData      (rd_data),
        .o_ramAddrIn   (ram_addr_in),
        .o_ramAddrOut  (ram_addr_out),
        .o_ramDataIn   (ram_data_in),
        .o_ramCs       (ram_cs),
        .o_ramWe       (ram_we),
        .i_ramDataOut  (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs === 1'b1 && ram_we === 1'b1) ram[ram_addr_in] <= ram_data_in;
        else if (ram_cs === 1'b1) ram_dout <= ram[ram_addr_out];
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // One clock of traffic: predict grants from the request/fairness rules, compare at
    // the falling edge, then advance the scoreboard.
    task automatic tick();
        bit            exp_rd, exp_wr, exp_cs, exp_we, exp_busy, exp_din;
        logic [AW-1:0] exp_ain;
        @(negedge clk);
        exp_busy = (clr_left > 0);
        exp_rd   = 1'b0;
        exp_wr   = 1'b0;
        exp_din  = wr_data;
        exp_ain  = wr_addr;
        if (exp_busy) begin
            exp_ain = AW'(DEPTH - clr_left);
            exp_din = clr_fill;
        end else if (rd_valid && wr_valid) begin
            exp_rd = !last_was_rd;
            exp_wr = last_was_rd;
        end else begin
            exp_rd = rd_valid;
            exp_wr = wr_valid;
        end
        exp_cs = exp_busy | exp_rd | exp_wr;
        exp_we = exp_busy | exp_wr;

        obs_wr_ready = wr_ready;
        obs_rd_ready = rd_ready;
        obs_busy     = clear_busy;
        obs_cs       = ram_cs;

        vectors++;
        if (rd_ready !== exp_rd) begin
            miscompares++;
            $display("FAIL rd_ready t=%0t got %b exp %b", $time, rd_ready, exp_rd);
        end
        vectors++;
        if (wr_ready !== exp_wr) begin
            miscompares++;
            $display("FAIL wr_ready t=%0t got %b exp %b", $time, wr_ready, exp_wr);
        end
        vectors++;
        if (clear_busy !== exp_busy) begin
            miscompares++;
            $display("FAIL clear_busy t=%0t got %b exp %b", $time, clear_busy, exp_busy);
        end
        vectors++;
        if (ram_cs !== exp_cs || ram_we !== exp_we) begin
            miscompares++;
            $display("FAIL ram_cs_we t=%0t got %b%b exp %b%b", $time, ram_cs, ram_we, exp_cs, exp_we);
        end
        if (exp_we) begin
            vectors++;
            if (ram_addr_in !== exp_ain || ram_data_in !== exp_din) begin
                miscompares++;
                $display("FAIL ram_write t=%0t got addr %h data %b exp addr %h data %b",
                         $time, ram_addr_in, ram_data_in, exp_ain, exp_din);
            end
        end
        if (exp_rd) begin
            vectors++;
            if (ram_addr_out !== rd_addr) begin
                miscompares++;
                $display("FAIL ram_addr_out t=%0t got %h exp %h", $time, ram_addr_out, rd_addr);
            end
        end
        vectors++;
        if (rd_data_valid !== rd_pend) begin
            miscompares++;
            $display("FAIL rd_data_valid t=%0t got %b exp %b", $time, rd_data_valid, rd_pend);
        end
        if (rd_pend) begin
            vectors++;
            if (rd_data !== rd_pend_data) begin
                miscompares++;
                $display("FAIL rd_data t=%0t got %b exp %b", $time, rd_data, rd_pend_data);
            end
        end

        rd_pend = 1'b0;
        if (exp_busy) begin
            ref_mem[DEPTH - clr_left] = clr_fill;
            clr_left--;
        end else begin
            if (exp_wr) begin
                ref_mem[wr_addr] = wr_data;
                last_was_rd = 1'b0;
            end
            if (exp_rd) begin
                rd_pend      = 1'b1;
                rd_pend_data = ref_mem[rd_addr];
                last_was_rd  = 1'b1;
            end
            if (clear_req && CLEAR_EN) begin
                clr_left = DEPTH;
                clr_fill = clear_val;
            end
        end
        acc_rd = exp_rd;
        acc_wr = exp_wr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rd_valid  = 1'b0;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        nRst      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr_left    = 0;
        last_was_rd = 1'b1;
        rd_pend     = 1'b0;
        nRst        = 1'b1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic d);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        do begin
            tick();
            n++;
        end while (!acc_wr && n < BOUND);
        wr_valid = 1'b0;
        vectors++;
        if (!acc_wr) begin
            miscompares++;
            $display("FAIL write_timeout addr %h got no grant, required grant", a);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int n = 0;
        rd_valid = 1'b1;
        rd_addr  = a;
        do begin
            tick();
            n++;
        end while (!acc_rd && n < BOUND);
        rd_valid = 1'b0;
        vectors++;
        if (!acc_rd) begin
            miscompares++;
            $display("FAIL read_timeout addr %h got no grant, required grant", a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < BOUND && (rd_valid || wr_valid); i++) begin
            tick();
            if (acc_rd) rd_valid = 1'b0;
            if (acc_wr) wr_valid = 1'b0;
        end
        vectors++;
        if (rd_valid || wr_valid) begin
            miscompares++;
            $display("FAIL drain_timeout got pending rd %b wr %b, required none", rd_valid, wr_valid);
            rd_valid = 1'b0;
            wr_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rd_valid  = 1'b0;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        nRst      = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({clear_busy, rd_data_valid, rd_data, ram_cs, ram_we, wr_ready, rd_ready} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b exp 0000000",
                     {clear_busy, rd_data_valid, rd_data, ram_cs, ram_we, wr_ready, rd_ready});
        end
        apply_reset();
    endtask

    task automatic test_write_read();
        do_write(14'h0123, 1'b1);
        tick();
        vectors++;
        if (obs_cs !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_cs got %b exp 0", obs_cs);
        end
        do_read(14'h0123);
        vectors++;
        if (rd_data_valid !== 1'b1 || rd_data !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_rd_0123 got valid %b data %b exp 1 1", rd_data_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        wr_valid = 1'b1;
        wr_addr  = 14'h0010;
        wr_data  = 1'b1;
        rd_valid = 1'b1;
        rd_addr  = 14'h0020;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs_wr_ready !== ((i % 2) == 0) || obs_rd_ready !== ((i % 2) == 1)) begin
                miscompares++;
                $display("FAIL rr_cycle%0d got wr %b rd %b exp wr %b rd %b", i,
                         obs_wr_ready, obs_rd_ready, (i % 2) == 0, (i % 2) == 1);
            end
        end
        drain();
        tick();
    endtask

    task automatic test_back_to_back_raw();
        do_write(14'h3FFF, 1'b1);
        do_read(14'h3FFF);
        vectors++;
        if (rd_data_valid !== 1'b1 || rd_data !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_3fff got valid %b data %b exp 1 1", rd_data_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_random(input int cycles, input bit pulse_clear);
        logic [AW-1:0] pool [8] = '{14'h0000, 14'h0001, 14'h0123, 14'h2000,
                                    14'h3FFF, 14'h0010, 14'h0020, 14'h0050};
        for (int i = 0; i < cycles; i++) begin
            if (!rd_valid && $urandom_range(0, 3) != 0) begin
                rd_valid = 1'b1;
                rd_addr  = pool[$urandom_range(0, 7)];
            end
            if (!wr_valid && $urandom_range(0, 3) != 0) begin
                wr_valid = 1'b1;
                wr_addr  = pool[$urandom_range(0, 7)];
                wr_data  = 1'($urandom);
            end
            clear_req = pulse_clear && (i % 16 == 3);
            clear_val = 1'($urandom);
            tick();
            clear_req = 1'b0;
            if (acc_rd) rd_valid = 1'b0;
            if (acc_wr) wr_valid = 1'b0;
        end
        drain();
        tick();
    endtask

`ifdef MASK_ARB_CLEAR_EN
    task automatic test_clear();
        int busy_cycles = 0;
        bit done = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 14'h0010;
        wr_data   = 1'b1;
        rd_valid  = 1'b1;
        rd_addr   = 14'h0020;
        clear_req = 1'b1;
        clear_val = 1'b1;
        tick();
        clear_req = 1'b0;
        clear_val = 1'b0;
        for (int i = 0; i < BOUND && !done; i++) begin
            clear_req = (busy_cycles == 5000);
            tick();
            clear_req = 1'b0;
            if (obs_busy === 1'b1) busy_cycles++;
            else done = 1'b1;
        end
        vectors++;
        if (busy_cycles != DEPTH) begin
            miscompares++;
            $display("FAIL clear_busy_len got %0d cycles exp %0d", busy_cycles, DEPTH);
        end
        drain();
        do_read(14'h0000);
        vectors++;
        if (rd_data !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_rd_0000 got %b exp 1", rd_data);
        end
        do_read(14'h2000);
        vectors++;
        if (rd_data !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_rd_2000 got %b exp 1", rd_data);
        end
        do_read(14'h3FFF);
        vectors++;
        if (rd_data !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_rd_3fff got %b exp 1", rd_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clear_req = 1'b1;
        clear_val = 1'b0;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        nRst = 1'b0;
        #1;
        vectors++;
        if (clear_busy !== 1'b0 || ram_cs !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_clear_reset got busy %b cs %b exp 0 0", clear_busy, ram_cs);
        end
        @(posedge clk);
        #1;
        clr_left    = 0;
        last_was_rd = 1'b1;
        rd_pend     = 1'b0;
        nRst        = 1'b1;
        do_write(14'h0050, 1'b0);
        do_write(14'h0050, 1'b1);
        do_read(14'h0050);
        vectors++;
        if (rd_data_valid !== 1'b1 || rd_data !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_0050 got valid %b data %b exp 1 1", rd_data_valid, rd_data);
        end
        do_read(14'h0063);
        do_read(14'h1000);
        repeat (20) tick();
    endtask
`else
    task automatic test_clear_disabled();
        int busy_seen = 0;
        for (int i = 0; i < 64; i++) begin
            if (!rd_valid) begin
                rd_valid = 1'b1;
                rd_addr  = AW'($urandom_range(0, 15));
            end
            if (!wr_valid) begin
                wr_valid = 1'b1;
                wr_addr  = AW'($urandom_range(0, 15));
                wr_data  = 1'($urandom);
            end
            clear_req = (i % 8 == 0);
            clear_val = 1'b1;
            tick();
            clear_req = 1'b0;
            if (obs_busy !== 1'b0) busy_seen++;
            if (acc_rd) rd_valid = 1'b0;
            if (acc_wr) wr_valid = 1'b0;
        end
        drain();
        vectors++;
        if (busy_seen != 0) begin
            miscompares++;
            $display("FAIL disabled_busy got %0d busy cycles exp 0", busy_seen);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_back_to_back_raw();
        test_random(400, 1'b0);
`ifdef MASK_ARB_CLEAR_EN
        test_clear();
        test_reset_mid_clear();
        test_random(200, 1'b0);
`else
        test_clear_disabled();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
